// File: rtl/dfr_dac_spi_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// dfr_dac_pkg : shared types, frame constants and the DAC code clamp.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package dfr_dac_pkg;

  localparam int          DAC_FRAME_BITS = 16;
  localparam logic [11:0] DAC_CODE_MAX   = 12'hFFF;

  // Frame config bits: unbuffered reference, 1x gain, output active.
  localparam logic BUF    = 1'b0;
  localparam logic GA_N   = 1'b1;
  localparam logic SHDN_N = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_HOLD  = 3'd2,
    ST_CSHI  = 3'd3,
    ST_LDAC  = 3'd4
  } dac_state_t;

  // Input is sign-extended to 64 bits by the caller, so any DATA_WIDTH <= 64 fits.
  function automatic logic [11:0] dac_clamp(input logic signed [63:0] x);
    if (x < 0)
      return 12'd0;
    else if (x > 64'sd4095)
      return DAC_CODE_MAX;
    else
      return x[11:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/dfr_dac_spi_ctrl_if.sv
// ----------------------------------------------------------------------------
// dfr_dac_spi_ctrl_if : sample handshake between sequencer and DAC ctrl. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface dfr_dac_spi_ctrl_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                         s_valid;
  logic                         s_ready;
  logic signed [DATA_WIDTH-1:0] s_data;
  logic                         s_chan;
  logic                         done;
  logic                         busy;

  modport master (output s_valid, s_data, s_chan, input s_ready, done, busy);
  modport slave  (input s_valid, s_data, s_chan, output s_ready, done, busy);

endinterface

`default_nettype wire

// File: rtl/dfr_dac_spi_ctrl_tick.sv
// ----------------------------------------------------------------------------
// dac_half_period_tick : one-cycle tick every CLK_DIV cycles while enabled. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dac_half_period_tick #(
  parameter int CLK_DIV = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic en,
  output logic      tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)
      cnt <= '0;
    else if (cnt == C_LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tick = en && (cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/dfr_dac_spi_ctrl.sv
// ----------------------------------------------------------------------------
// dfr_dac_spi_ctrl : clamps a reservoir sample and ships it to the SPI DAC. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dfr_dac_spi_ctrl
  import dfr_dac_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int LDAC_CYCLES = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  wire logic          clk,
  input  wire logic          rst,
  dfr_dac_spi_ctrl_if.slave  s,
  output logic               DAC_CS_N,
  output logic               DAC_SCLK,
  output logic               DAC_DIN,
  output logic               DAC_LDAC_N
);

  localparam int LW = (LDAC_CYCLES > 1) ? $clog2(LDAC_CYCLES) : 1;
  localparam logic [LW-1:0] C_LDAC_LAST = LW'(LDAC_CYCLES - 1);

  dac_state_t                    state;
  logic [DAC_FRAME_BITS-1:0]     shreg;
  logic [3:0]                    bit_cnt;
  logic [LW-1:0]                 ldac_cnt;
  logic                          cs_n, sclk, ldac_n, ready, busy_r, done_r;
  logic                          tick_en, tick;
  logic signed [DATA_WIDTH-1:0]  sample;
  logic [11:0]                   code;

  assign sample  = s.s_data;
  assign code    = dac_clamp(64'(sample));
  assign tick_en = (state == ST_SHIFT) || (state == ST_HOLD) || (state == ST_CSHI);

  dac_half_period_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      ldac_cnt <= '0;
      cs_n     <= 1'b1;
      sclk     <= 1'b0;
      ldac_n   <= 1'b1;
      ready    <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s.s_valid) begin
            state   <= ST_SHIFT;
            shreg   <= {s.s_chan, BUF, GA_N, SHDN_N, code};
            bit_cnt <= '0;
            cs_n    <= 1'b0;
            sclk    <= 1'b0;
            ready   <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // DIN is shreg MSB, so shifting on the falling tick moves DIN only at bit start.
          if (tick) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              sclk  <= 1'b0;
              shreg <= {shreg[DAC_FRAME_BITS-2:0], 1'b0};
              if (bit_cnt == 4'd15)
                state <= ST_HOLD;
              else
                bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state <= ST_CSHI;
            cs_n  <= 1'b1;
          end
        end
        ST_CSHI: begin
          if (tick) begin
            state    <= ST_LDAC;
            ldac_n   <= 1'b0;
            ldac_cnt <= '0;
          end
        end
        ST_LDAC: begin
          if (ldac_cnt == C_LDAC_LAST) begin
            state  <= ST_IDLE;
            ldac_n <= 1'b1;
            done_r <= 1'b1;
            ready  <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            ldac_cnt <= ldac_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign s.s_ready  = ready;
  assign s.busy     = busy_r;
  assign s.done     = done_r;
  assign DAC_CS_N   = cs_n;
  assign DAC_SCLK   = sclk;
  assign DAC_DIN    = shreg[DAC_FRAME_BITS-1];
  assign DAC_LDAC_N = ldac_n;

endmodule

`default_nettype wire

// File: tb/tb_dfr_dac_spi_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dfr_dac_spi_ctrl : randomized frame checks for default and fast DUTs. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dfr_dac_spi_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] data = '0;
  logic        chan = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  dfr_dac_spi_ctrl_if #(.DATA_WIDTH(32)) bus0 ();
  dfr_dac_spi_ctrl_if #(.DATA_WIDTH(32)) bus1 ();
  assign bus0.s_valid = valid;
  assign bus0.s_data  = data;
  assign bus0.s_chan  = chan;
  assign bus1.s_valid = valid;
  assign bus1.s_data  = data;
  assign bus1.s_chan  = chan;

  logic cs0, sclk0, din0, ldac0, cs1, sclk1, din1, ldac1;

  dfr_dac_spi_ctrl #(.CLK_DIV(2), .LDAC_CYCLES(2), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s(bus0.slave),
    .DAC_CS_N(cs0), .DAC_SCLK(sclk0), .DAC_DIN(din0), .DAC_LDAC_N(ldac0)
  );

  dfr_dac_spi_ctrl #(.CLK_DIV(1), .LDAC_CYCLES(1), .DATA_WIDTH(32)) dut_fast (
    .clk(clk), .rst(rst), .s(bus1.slave),
    .DAC_CS_N(cs1), .DAC_SCLK(sclk1), .DAC_DIN(din1), .DAC_LDAC_N(ldac1)
  );

  // {cs_n, sclk, din, ldac_n, done, s_ready, busy}
  function automatic logic [6:0] pins(input int which);
    if (which == 0)
      return {cs0, sclk0, din0, ldac0, bus0.done, bus0.s_ready, bus0.busy};
    return {cs1, sclk1, din1, ldac1, bus1.done, bus1.s_ready, bus1.busy};
  endfunction

  // Expected frame straight from the clamp/frame rules.
  function automatic logic [15:0] model_frame(input logic [31:0] d, input logic c);
    longint v;
    longint code;
    v = longint'($signed(d));
    if (v < 0)         code = 0;
    else if (v > 4095) code = 4095;
    else               code = v;
    return 16'((c ? 32768 : 0) + 12288 + code);
  endfunction

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus0.s_ready && bus1.s_ready) break;
    end
    n_checks++;
    if (k == 300) begin
      n_fail++;
      $display("FAIL idle_timeout: ready0=%0b ready1=%0b required both 1", bus0.s_ready, bus1.s_ready);
    end
  endtask

  task automatic send(input int which, input logic [31:0] d, input logic c);
    logic [6:0] p;
    wait_idle();
    p = pins(which);
    n_checks++;
    if (p[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL send_ready: s_ready=%0b required 1", p[1]);
    end
    valid = 1'b1;
    data  = d;
    chan  = c;
    @(posedge clk);
  endtask

  // Watches one frame from cycle 1 (first negedge after accept) until done.
  task automatic observe(input int which, input bit drop_valid,
                         output logic [15:0] frame, output int nbits,
                         output int cs_cnt, output int cs_first, output int cs_last,
                         output int ld_first, output int ld_last, output int done_cyc,
                         output int rdy_bad, output int din_bad);
    logic [6:0] p;
    logic prev_sclk, prev_din;
    frame = '0; nbits = 0; cs_cnt = 0; cs_first = 0; cs_last = 0;
    ld_first = 0; ld_last = 0; done_cyc = -1; rdy_bad = 0; din_bad = 0;
    prev_sclk = 1'b0;
    prev_din  = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (n == 1) begin
        if (drop_valid) valid = 1'b0;
        data = $urandom;
        chan = 1'($urandom);
      end
      p = pins(which);
      if (!p[6]) begin cs_cnt++; if (cs_first == 0) cs_first = n; cs_last = n; end
      if (!p[3]) begin if (ld_first == 0) ld_first = n; ld_last = n; end
      if (p[5] && !prev_sclk) begin frame = {frame[14:0], p[4]}; nbits++; end
      if ((p[4] !== prev_din) && p[5]) din_bad++;
      if (p[1] === p[0]) rdy_bad++;
      if (p[2]) begin
        done_cyc = n;
        if (!p[1]) rdy_bad++;
        break;
      end else if (p[1]) begin
        rdy_bad++;
      end
      prev_sclk = p[5];
      prev_din  = p[4];
    end
  endtask

  task automatic check_frame(input string nm, input int which, input logic [15:0] exp,
                             input logic [15:0] fr, input int nbits, input int cs_cnt,
                             input int cs_first, input int cs_last, input int ld_first,
                             input int ld_last, input int done_cyc, input int rdy_bad,
                             input int din_bad);
    int h, l;
    h = (which == 0) ? 2 : 1;
    l = (which == 0) ? 2 : 1;
    n_checks += 8;
    if (fr !== exp || nbits != 16) begin
      n_fail++; $display("FAIL %s frame: got 0x%04h (%0d bits) required 0x%04h (16 bits)", nm, fr, nbits, exp);
    end
    if (cs_cnt != 33*h) begin
      n_fail++; $display("FAIL %s cs_low_count: got %0d required %0d", nm, cs_cnt, 33*h);
    end
    if (cs_first != 1 || cs_last != 33*h) begin
      n_fail++; $display("FAIL %s cs_window: got %0d..%0d required 1..%0d", nm, cs_first, cs_last, 33*h);
    end
    if (ld_first != 34*h+1) begin
      n_fail++; $display("FAIL %s ldac_first: got %0d required %0d", nm, ld_first, 34*h+1);
    end
    if (ld_last != 34*h+l) begin
      n_fail++; $display("FAIL %s ldac_last: got %0d required %0d", nm, ld_last, 34*h+l);
    end
    if (done_cyc != 34*h+l+1) begin
      n_fail++; $display("FAIL %s done_cycle: got %0d required %0d", nm, done_cyc, 34*h+l+1);
    end
    if (rdy_bad != 0) begin
      n_fail++; $display("FAIL %s ready_busy: got %0d bad cycles required 0", nm, rdy_bad);
    end
    if (din_bad != 0) begin
      n_fail++; $display("FAIL %s din_stable: got %0d changes while SCLK high required 0", nm, din_bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (pins(0) !== 7'b1001010) begin
      n_fail++; $display("FAIL reset_dut: got %b required 1001010", pins(0));
    end
    if (pins(1) !== 7'b1001010) begin
      n_fail++; $display("FAIL reset_dut_fast: got %b required 1001010", pins(1));
    end
  endtask

  task automatic test_frame(input string nm, input int which, input logic [31:0] d, input logic c);
    logic [15:0] fr;
    int nb, cc, cf, cl, lf, ll, dc, rb, db;
    send(which, d, c);
    observe(which, 1'b1, fr, nb, cc, cf, cl, lf, ll, dc, rb, db);
    check_frame(nm, which, model_frame(d, c), fr, nb, cc, cf, cl, lf, ll, dc, rb, db);
  endtask

  task automatic test_random(input int count);
    logic [31:0] d;
    for (int i = 0; i < count; i++) begin
      case (i % 3)
        0:       d = $urandom;
        1:       d = 32'($urandom_range(0, 4095));
        default: d = 32'($urandom_range(4000, 4200));
      endcase
      test_frame("random", 0, d, 1'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fr;
    int nb, cc, cf, cl, lf, ll, dc, rb, db;
    logic [31:0] d1, d2;
    logic c1, c2;
    d1 = 32'($urandom_range(0, 4095)); c1 = 1'($urandom);
    d2 = 32'($urandom_range(0, 4095)); c2 = 1'($urandom);
    send(0, d1, c1);
    observe(0, 1'b0, fr, nb, cc, cf, cl, lf, ll, dc, rb, db);
    check_frame("b2b_first", 0, model_frame(d1, c1), fr, nb, cc, cf, cl, lf, ll, dc, rb, db);
    data = d2;
    chan = c2;
    observe(0, 1'b1, fr, nb, cc, cf, cl, lf, ll, dc, rb, db);
    check_frame("b2b_second", 0, model_frame(d2, c2), fr, nb, cc, cf, cl, lf, ll, dc, rb, db);
    rb = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!cs0 || !bus0.s_ready) rb++;
    end
    n_checks++;
    if (rb != 0) begin
      n_fail++; $display("FAIL b2b_no_third: got %0d busy cycles after second frame required 0", rb);
    end
  endtask

  task automatic test_rst_mid_frame();
    int bad;
    send(0, $urandom, 1'($urandom));
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (pins(0) !== 7'b1001010) begin
      n_fail++; $display("FAIL rst_mid_values: got %b required 1001010", pins(0));
    end
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (bus0.done || !cs0 || !ldac0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles required 0", bad);
    end
    test_frame("after_rst", 0, 32'($urandom_range(0, 4095)), 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_frame("abc", 0, 32'h0000_0ABC, 1'b0);
    test_frame("neg5", 0, -32'sd5, 1'b1);
    test_frame("over", 0, 32'd5000, 1'b0);
    test_frame("max", 0, 32'd4095, 1'b0);
    test_random(6);
    test_back_to_back();
    test_frame("fast", 1, 32'($urandom_range(0, 4095)), 1'($urandom));
    test_frame("fast_neg", 1, 32'h8000_0000, 1'b1);
    test_rst_mid_frame();
    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
